// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED frame sequencer and its neighbours.
package led_seq_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SHIFT_WAIT = 3'd1,
      LATCH      = 3'd2,
      BLANK_POST = 3'd3,
      RUN        = 3'd4
   } seq_state_t;

   localparam int DEF_GS_BITS      = 12;
   localparam int DEF_GSCLK_DIV    = 2;
   localparam int DEF_ROWS         = 8;
   localparam int DEF_XLAT_CYCLES  = 2;
   localparam int DEF_BLANK_CYCLES = 4;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

   // Width of a counter that runs 0..value-1, never narrower than one bit.
   function automatic int bits_for(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Row-shift handshake between the frame sequencer (master) and the serial shifter (slave).
interface led_frame_sequencer_if #(
   parameter int ROW_W = led_seq_pkg::clog2(led_seq_pkg::DEF_ROWS)
) ();

   logic             shift_start;
   logic [ROW_W-1:0] shift_row;
   logic             shift_done;

   modport master (output shift_start, output shift_row, input shift_done);
   modport slave  (input shift_start, input shift_row, output shift_done);

endinterface

// File: rtl/led_gsclk_gen.sv
// Grayscale clock generator: divides the system clock while run is high and flags the
// final falling toggle after 2**GS_BITS rising edges.
module led_gsclk_gen
   import led_seq_pkg::*;
#(
   parameter int GS_BITS   = DEF_GS_BITS,
   parameter int GSCLK_DIV = DEF_GSCLK_DIV
) (
   input  logic clock,
   input  logic reset_n,
   input  logic run,
   output logic gsclk,
   output logic window_done
);

   localparam int DIV_W  = bits_for(GSCLK_DIV);
   localparam int EDGE_W = GS_BITS + 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(GSCLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 ** GS_BITS);

   logic [DIV_W-1:0]  div_q, div_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic              gsclk_q, gsclk_d;
   logic              toggle;

   always_comb begin
      toggle      = run && (div_q == DIV_LAST);
      // The last rising edge is already counted, so the next toggle is the closing fall.
      window_done = toggle && gsclk_q && (edge_q == EDGE_LAST);
      div_d       = div_q;
      edge_d      = edge_q;
      gsclk_d     = gsclk_q;
      if (!run || window_done) begin
         div_d   = '0;
         edge_d  = '0;
         gsclk_d = 1'b0;
      end else if (toggle) begin
         div_d   = '0;
         gsclk_d = !gsclk_q;
         if (!gsclk_q) edge_d = edge_q + 1'b1;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         edge_q  <= '0;
         gsclk_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         edge_q  <= edge_d;
         gsclk_q <= gsclk_d;
      end
   end

   assign gsclk = gsclk_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// TLC5940-style chain sequencer: PWM window, background row shift request, XLAT latch,
// plus synchronised and gated driver-error capture.
module led_frame_sequencer
   import led_seq_pkg::*;
#(
   parameter int GS_BITS      = DEF_GS_BITS,
   parameter int GSCLK_DIV    = DEF_GSCLK_DIV,
   parameter int ROWS         = DEF_ROWS,
   parameter int XLAT_CYCLES  = DEF_XLAT_CYCLES,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   localparam int ROW_W       = clog2(ROWS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   led_frame_sequencer_if.master shf,
   output logic                  led_gsclk,
   output logic                  led_blank,
   output logic                  led_xlat,
   output logic                  led_mode,
   output logic [ROW_W-1:0]      row_index,
   output logic                  frame_tick,
   input  logic                  led_xerr,
   input  logic                  xerr_clear,
   output logic                  xerr_flag
);

   localparam int CNT_MAX = (XLAT_CYCLES > BLANK_CYCLES) ? XLAT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = bits_for(CNT_MAX);
   localparam logic [CNT_W-1:0] XLAT_LAST  = CNT_W'(XLAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

   seq_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       run_age_q;
   logic             pending_q;
   logic             shift_start_q;
   logic [ROW_W-1:0] shift_row_q;
   logic [ROW_W-1:0] row_index_q;
   logic             frame_tick_q;
   logic             blank_q;
   logic             xlat_q;
   logic [1:0]       xerr_sync_q;
   logic             xerr_flag_q, xerr_flag_d;
   logic             xerr_set;
   logic [ROW_W-1:0] next_row;
   logic             window_done;

   led_gsclk_gen #(
      .GS_BITS   (GS_BITS),
      .GSCLK_DIV (GSCLK_DIV)
   ) u_gsclk (
      .clock       (clock),
      .reset_n     (reset_n),
      .run         (state_q == RUN),
      .gsclk       (led_gsclk),
      .window_done (window_done)
   );

   assign next_row = (row_index_q == ROW_LAST) ? '0 : row_index_q + 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         run_age_q     <= '0;
         pending_q     <= 1'b0;
         shift_start_q <= 1'b0;
         shift_row_q   <= '0;
         row_index_q   <= '0;
         frame_tick_q  <= 1'b0;
         blank_q       <= 1'b1;
         xlat_q        <= 1'b0;
      end else begin
         shift_start_q <= 1'b0;
         frame_tick_q  <= 1'b0;
         // A start is only issued with pending clear, so the set below never races this clear.
         if (shf.shift_done && pending_q) pending_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  shift_start_q <= 1'b1;
                  shift_row_q   <= '0;
                  pending_q     <= 1'b1;
                  state_q       <= SHIFT_WAIT;
               end
            end
            SHIFT_WAIT: begin
               if (!pending_q) begin
                  state_q      <= LATCH;
                  xlat_q       <= 1'b1;
                  row_index_q  <= shift_row_q;
                  frame_tick_q <= (shift_row_q == ROW_LAST);
                  cnt_q        <= '0;
               end
            end
            LATCH: begin
               if (cnt_q == XLAT_LAST) begin
                  xlat_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= BLANK_POST;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            BLANK_POST: begin
               if (cnt_q == BLANK_LAST) begin
                  cnt_q <= '0;
                  if (enable) begin
                     state_q       <= RUN;
                     blank_q       <= 1'b0;
                     shift_start_q <= 1'b1;
                     shift_row_q   <= next_row;
                     pending_q     <= 1'b1;
                     run_age_q     <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (run_age_q != 2'd2) run_age_q <= run_age_q + 1'b1;
               if (window_done) begin
                  state_q <= SHIFT_WAIT;
                  blank_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               blank_q <= 1'b1;
               xlat_q  <= 1'b0;
            end
         endcase
      end
   end

   // XERR is only meaningful once the drivers have settled into the PWM window.
   always_comb begin
      xerr_set    = (state_q == RUN) && (run_age_q == 2'd2) && !xerr_sync_q[1];
      xerr_flag_d = xerr_set || (xerr_flag_q && !xerr_clear);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         xerr_sync_q <= 2'b11;
         xerr_flag_q <= 1'b0;
      end else begin
         xerr_sync_q <= {xerr_sync_q[0], led_xerr};
         xerr_flag_q <= xerr_flag_d;
      end
   end

   assign shf.shift_start = shift_start_q;
   assign shf.shift_row   = shift_row_q;
   assign led_blank       = blank_q;
   assign led_xlat        = xlat_q;
   assign led_mode        = 1'b0;
   assign row_index       = row_index_q;
   assign frame_tick      = frame_tick_q;
   assign xerr_flag       = xerr_flag_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: segment-level timeline model with random shifter delays,
// a table of XERR vectors, and directed disable / async-reset sequences.
module tb_led_frame_sequencer;

   localparam int GS_BITS   = 4;
   localparam int GSCLK_DIV = 1;
   localparam int ROWS      = 4;
   localparam int XLAT_C    = 1;
   localparam int BLANK_C   = 2;
   localparam int ROW_W     = 2;
   localparam int RUNLEN    = 2 * GSCLK_DIV * (2 ** GS_BITS);
   localparam int MAXC      = 3000;
   localparam int NROWS     = 12;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic led_xerr = 1'b1;
   logic xerr_clear = 1'b0;
   logic led_gsclk, led_blank, led_xlat, led_mode, frame_tick, xerr_flag;
   logic [ROW_W-1:0] row_index;

   led_frame_sequencer_if #(.ROW_W(ROW_W)) sif ();

   led_frame_sequencer #(
      .GS_BITS      (GS_BITS),
      .GSCLK_DIV    (GSCLK_DIV),
      .ROWS         (ROWS),
      .XLAT_CYCLES  (XLAT_C),
      .BLANK_CYCLES (BLANK_C)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .shf        (sif),
      .led_gsclk  (led_gsclk),
      .led_blank  (led_blank),
      .led_xlat   (led_xlat),
      .led_mode   (led_mode),
      .row_index  (row_index),
      .frame_tick (frame_tick),
      .led_xerr   (led_xerr),
      .xerr_clear (xerr_clear),
      .xerr_flag  (xerr_flag)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   bit auto_shf = 1'b0;
   int auto_dly = 1;
   int shf_cnt = 0;

   // Expected per-cycle outputs built from window segments.
   bit e_bl [MAXC];
   bit e_gs [MAXC];
   bit e_xl [MAXC];
   bit e_ft [MAXC];
   bit e_st [MAXC];
   bit dsch [MAXC];
   int e_ri [MAXC];
   int e_sr [MAXC];
   int dly  [NROWS];
   bit spur [NROWS];

   typedef struct {
      bit xerr;
      bit clr;
      bit exp_flag;
   } xvec_t;
   xvec_t xv [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      sif.shift_done = 1'b0;
      if (auto_shf) begin
         if (shf_cnt > 0) begin
            shf_cnt--;
            if (shf_cnt == 0) sif.shift_done = 1'b1;
         end
         if (sif.shift_start === 1'b1) shf_cnt = auto_dly;
      end
   endtask

   task automatic do_reset(input bit en);
      reset_n = 1'b0;
      enable = en;
      led_xerr = 1'b1;
      xerr_clear = 1'b0;
      sif.shift_done = 1'b0;
      auto_shf = 1'b0;
      shf_cnt = 0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // which: 0 = blank low, 1 = xlat high, 2 = blank high
   task automatic wait_cond(input int which, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if ((which == 0 && led_blank == 1'b0) || (which == 1 && led_xlat == 1'b1) ||
             (which == 2 && led_blank == 1'b1)) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic build_timeline(output int last);
      int s, w, l, r, row;
      for (int t = 0; t < MAXC; t++) begin
         e_bl[t] = 1'b1; e_gs[t] = 1'b0; e_xl[t] = 1'b0; e_ft[t] = 1'b0;
         e_st[t] = 1'b0; dsch[t] = 1'b0; e_ri[t] = 0; e_sr[t] = 0;
      end
      s = 1;
      e_st[1] = 1'b1;
      row = 0;
      last = 0;
      for (int i = 0; i < NROWS; i++) begin
         dsch[s + dly[i]] = 1'b1;
         if (spur[i]) dsch[s + dly[i] + 2] = 1'b1;
         w = (i == 0) ? s : s + RUNLEN;
         l = ((w > s + dly[i] + 1) ? w : s + dly[i] + 1) + 1;
         e_xl[l] = 1'b1;
         e_ft[l] = (row == ROWS - 1);
         for (int t = l; t < MAXC; t++) e_ri[t] = row;
         r = l + XLAT_C + BLANK_C;
         for (int k = 0; k < RUNLEN; k++) begin
            e_bl[r + k] = 1'b0;
            e_gs[r + k] = ((k / GSCLK_DIV) % 2) == 1;
         end
         e_st[r] = 1'b1;
         row = (row + 1) % ROWS;
         for (int t = r; t < MAXC; t++) e_sr[t] = row;
         s = r;
         last = r + RUNLEN - 1;
      end
   endtask

   task automatic check_timeline(input int t);
      logic [31:0] act, exp;
      act = 32'({led_blank, led_gsclk, led_xlat, frame_tick, sif.shift_start,
                 xerr_flag, led_mode, row_index, sif.shift_row});
      exp = 32'({e_bl[t], e_gs[t], e_xl[t], e_ft[t], e_st[t], 1'b0, 1'b0,
                 2'(e_ri[t]), 2'(e_sr[t])});
      check($sformatf("timeline cycle %0d", t), act, exp);
   endtask

   initial begin
      int last_c;
      int cnt;
      bit quiet;

      xv[0]  = '{1'b1, 1'b0, 1'b0};
      xv[1]  = '{1'b0, 1'b0, 1'b0};
      xv[2]  = '{1'b0, 1'b0, 1'b0};
      xv[3]  = '{1'b0, 1'b0, 1'b0};
      xv[4]  = '{1'b1, 1'b0, 1'b1};
      xv[5]  = '{1'b1, 1'b0, 1'b1};
      xv[6]  = '{1'b1, 1'b0, 1'b1};
      xv[7]  = '{1'b1, 1'b1, 1'b1};
      xv[8]  = '{1'b1, 1'b0, 1'b0};
      xv[9]  = '{1'b0, 1'b0, 1'b0};
      xv[10] = '{1'b1, 1'b0, 1'b0};
      xv[11] = '{1'b1, 1'b1, 1'b0};
      xv[12] = '{1'b1, 1'b0, 1'b1};
      xv[13] = '{1'b1, 1'b0, 1'b1};

      sif.shift_done = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      check("reset blank", 32'(led_blank), 32'd1);
      check("reset gsclk", 32'(led_gsclk), 32'd0);
      check("reset xlat", 32'(led_xlat), 32'd0);
      check("reset mode", 32'(led_mode), 32'd0);
      check("reset row_index", 32'(row_index), 32'd0);
      check("reset frame_tick", 32'(frame_tick), 32'd0);
      check("reset shift_start", 32'(sif.shift_start), 32'd0);
      check("reset shift_row", 32'(sif.shift_row), 32'd0);
      check("reset xerr_flag", 32'(xerr_flag), 32'd0);

      // Timeline: startup, steady rows, late shifter, random delays, spurious dones
      dly[0] = 3;
      dly[1] = 1; dly[2] = 1; dly[3] = 1;
      dly[4] = RUNLEN + 50;
      for (int i = 5; i < NROWS; i++) dly[i] = int'($urandom_range(1, 60));
      for (int i = 0; i < NROWS; i++) spur[i] = (i >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      spur[2] = 1'b1;
      build_timeline(last_c);
      do_reset(1'b1);
      check_timeline(0);
      sif.shift_done = dsch[0];
      for (int t = 1; t <= last_c; t++) begin
         step();
         check_timeline(t);
         sif.shift_done = dsch[t];
      end

      // XERR vectors applied from RUN cycle 4 onward
      do_reset(1'b1);
      auto_shf = 1'b1;
      auto_dly = 1;
      wait_cond(0, "xerr run start");
      repeat (4) step();
      for (int i = 0; i < 14; i++) begin
         check($sformatf("xerr vector %0d", i), 32'(xerr_flag), 32'(xv[i].exp_flag));
         led_xerr = xv[i].xerr;
         xerr_clear = xv[i].clr;
         step();
      end
      led_xerr = 1'b1;
      xerr_clear = 1'b1;
      step();
      xerr_clear = 1'b0;
      step();
      check("xerr cleared", 32'(xerr_flag), 32'd0);
      wait_cond(1, "xerr latch");
      step();
      led_xerr = 1'b0;
      step();
      step();
      led_xerr = 1'b1;
      repeat (4) step();
      check("xerr in blank_post ignored", 32'(xerr_flag), 32'd0);

      // Disable mid-RUN
      do_reset(1'b1);
      auto_shf = 1'b1;
      wait_cond(0, "disable run start");
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (i == 9) enable = 1'b0;
         if (led_blank == 1'b0) cnt++;
         else break;
      end
      check("disable run length", 32'(cnt), 32'(RUNLEN));
      wait_cond(1, "disable latch");
      check("disable latched row", 32'(row_index), 32'd1);
      quiet = 1'b1;
      for (int i = 0; i < BLANK_C + 6; i++) begin
         step();
         if (led_blank != 1'b1 || sif.shift_start != 1'b0) quiet = 1'b0;
      end
      check("idle blank and quiet", 32'(quiet), 32'd1);
      enable = 1'b1;
      step();
      check("re-enable shift_start", 32'(sif.shift_start), 32'd1);
      check("re-enable shift_row", 32'(sif.shift_row), 32'd0);

      // Async reset at RUN cycle 7 of the second window
      do_reset(1'b1);
      auto_shf = 1'b1;
      wait_cond(0, "arst first run");
      wait_cond(2, "arst first run end");
      wait_cond(0, "arst second run");
      repeat (7) step();
      check("arst pre gsclk", 32'(led_gsclk), 32'd1);
      check("arst pre row_index", 32'(row_index), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("arst blank", 32'(led_blank), 32'd1);
      check("arst gsclk", 32'(led_gsclk), 32'd0);
      check("arst xlat", 32'(led_xlat), 32'd0);
      check("arst row_index", 32'(row_index), 32'd0);
      shf_cnt = 0;
      @(negedge clock);
      reset_n = 1'b1;
      step();
      check("arst restart shift_start", 32'(sif.shift_start), 32'd1);
      check("arst restart shift_row", 32'(sif.shift_row), 32'd0);
      wait_cond(0, "arst restart run");
      check("arst restart row_index", 32'(row_index), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
